// File: rtl/bullet_wave_scheduler.sv
// bullet_wave_scheduler: sequences bullet slots during the dodge phase.
// Slots are enabled on a frame cadence and retired when they hit the soul.
// Each damaging hit costs HP and opens an invulnerability window.
// The wave ends in phase completion, death, or an early exit from the phase.
module bullet_wave_scheduler #(
  parameter int NUM_BULLETS   = 4,
  parameter int SPAWN_FRAMES  = 30,
  parameter int WAVE_FRAMES   = 300,
  parameter int INVULN_FRAMES = 60,
  parameter int HP_INIT       = 20,
  parameter int DAMAGE        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             state,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic [NUM_BULLETS-1:0] collision,
  output logic [NUM_BULLETS-1:0] bullet_en,
  output logic [7:0]             hp,
  output logic                   hit_flash,
  output logic                   phase_done,
  output logic                   game_over,
  output logic [1:0]             dbg_fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2,
    S_DEAD   = 2'd3
  } fsm_t;

  localparam logic [9:0] WAVE_LAST = 10'(WAVE_FRAMES - 1);
  localparam logic [7:0] SPAWN_L   = 8'(SPAWN_FRAMES);
  localparam logic [7:0] INVULN_L  = 8'(INVULN_FRAMES);
  localparam logic [7:0] HP_INIT_L = 8'(HP_INIT);
  localparam logic [7:0] DAMAGE_L  = 8'(DAMAGE);
  localparam logic [2:0] LAST_SLOT = 3'(NUM_BULLETS - 1);
  localparam logic [NUM_BULLETS-1:0] SLOT0 = NUM_BULLETS'(1);

  fsm_t                   fsm_q, fsm_d;
  logic [9:0]             frame_cnt_q, frame_cnt_d;
  logic [7:0]             spawn_cnt_q, spawn_cnt_d;
  logic [7:0]             invuln_cnt_q, invuln_cnt_d;
  logic [2:0]             slot_idx_q, slot_idx_d;
  logic [NUM_BULLETS-1:0] bullet_en_q, bullet_en_d;
  logic [7:0]             hp_q, hp_d;
  logic                   hit_flash_q, hit_flash_d;
  logic                   phase_done_q, phase_done_d;
  logic                   game_over_q, game_over_d;
  logic                   end_cond_d_q, end_cond_d_d;

  logic                   end_cond;
  logic                   tick;
  logic [NUM_BULLETS-1:0] hit_vec;
  logic                   hit;
  logic [7:0]             spawn_next;
  logic [2:0]             slot_next;

  // Frame tick: one clk pulse on the rising edge of the last-pixel condition,
  // since the pixel coordinates hold for several clk cycles.
  always_comb begin
    end_cond     = (x == 10'd639) && (y == 10'd479);
    tick         = end_cond && !end_cond_d_q;
    end_cond_d_d = end_cond;
    // Only live slots can hit, and only outside the invulnerability window.
    hit_vec      = collision & bullet_en_q;
    hit          = (|hit_vec) && (invuln_cnt_q == 8'd0);
  end

  // Wave sequencing, spawn cadence, damage and invulnerability.
  always_comb begin
    fsm_d        = fsm_q;
    frame_cnt_d  = frame_cnt_q;
    spawn_cnt_d  = spawn_cnt_q;
    invuln_cnt_d = invuln_cnt_q;
    slot_idx_d   = slot_idx_q;
    bullet_en_d  = bullet_en_q;
    hp_d         = hp_q;
    phase_done_d = 1'b0;
    game_over_d  = game_over_q;
    spawn_next   = spawn_cnt_q + 8'd1;
    slot_next    = slot_idx_q + 3'd1;

    // The window drains on frame ticks; a fresh hit below overrides this.
    if (tick && (invuln_cnt_q != 8'd0)) begin
      invuln_cnt_d = invuln_cnt_q - 8'd1;
    end

    case (fsm_q)
      S_IDLE: begin
        bullet_en_d = '0;
        if (state == 4'd1) begin
          frame_cnt_d  = '0;
          spawn_cnt_d  = '0;
          slot_idx_d   = '0;
          invuln_cnt_d = '0;
          bullet_en_d  = SLOT0;
          fsm_d        = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (state != 4'd1) begin
          // Leaving the dodge phase early: no completion pulse, HP kept.
          bullet_en_d = '0;
          fsm_d       = S_IDLE;
        end else begin
          if (tick) begin
            frame_cnt_d = frame_cnt_q + 10'd1;
            spawn_cnt_d = spawn_next;
            if ((spawn_next == SPAWN_L) && (slot_idx_q < LAST_SLOT)) begin
              spawn_cnt_d = '0;
              slot_idx_d  = slot_next;
              for (int i = 0; i < NUM_BULLETS; i++) begin
                if (3'(i) == slot_next) bullet_en_d[i] = 1'b1;
              end
            end
          end
          if (hit) begin
            // Hit slots retire; damage applies once per cycle regardless of count.
            bullet_en_d  = bullet_en_d & ~hit_vec;
            hp_d         = (hp_q > DAMAGE_L) ? (hp_q - DAMAGE_L) : 8'd0;
            invuln_cnt_d = INVULN_L;
          end
          // Death takes priority over a timeout landing in the same cycle.
          if (hp_d == 8'd0) begin
            bullet_en_d = '0;
            game_over_d = 1'b1;
            fsm_d       = S_DEAD;
          end else if (tick && (frame_cnt_d == WAVE_LAST)) begin
            bullet_en_d  = '0;
            phase_done_d = 1'b1;
            fsm_d        = S_DONE;
          end
        end
      end

      S_DONE: begin
        bullet_en_d = '0;
        if (state != 4'd1) fsm_d = S_IDLE;
      end

      default: begin
        bullet_en_d = '0;
        game_over_d = 1'b1;
      end
    endcase

    hit_flash_d = (invuln_cnt_d != 8'd0);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q        <= S_IDLE;
      frame_cnt_q  <= '0;
      spawn_cnt_q  <= '0;
      invuln_cnt_q <= '0;
      slot_idx_q   <= '0;
      bullet_en_q  <= '0;
      hp_q         <= HP_INIT_L;
      hit_flash_q  <= 1'b0;
      phase_done_q <= 1'b0;
      game_over_q  <= 1'b0;
      end_cond_d_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      frame_cnt_q  <= frame_cnt_d;
      spawn_cnt_q  <= spawn_cnt_d;
      invuln_cnt_q <= invuln_cnt_d;
      slot_idx_q   <= slot_idx_d;
      bullet_en_q  <= bullet_en_d;
      hp_q         <= hp_d;
      hit_flash_q  <= hit_flash_d;
      phase_done_q <= phase_done_d;
      game_over_q  <= game_over_d;
      end_cond_d_q <= end_cond_d_d;
    end
  end

  assign bullet_en     = bullet_en_q;
  assign hp            = hp_q;
  assign hit_flash     = hit_flash_q;
  assign phase_done    = phase_done_q;
  assign game_over     = game_over_q;
  assign dbg_fsm_state = fsm_q;

endmodule

// File: tb/tb_bullet_wave_scheduler.sv
// Bench for bullet_wave_scheduler: table of directed operations with
// hand-computed expected outputs, then hand-written multi-cycle sequences.
module tb_bullet_wave_scheduler;

  localparam int OP_RESET = 0;
  localparam int OP_STATE = 1;
  localparam int OP_TICKS = 2;
  localparam int OP_HIT   = 3;
  localparam int OP_IDLE  = 4;

  typedef struct {
    int         op;
    int         arg;
    logic [3:0] en;
    logic [7:0] hp;
    logic       flash;
    logic       chk_flash;
    logic       done;
    logic       over;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] state = 4'd0;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic [3:0] collision = 4'd0;
  logic [3:0] bullet_en;
  logic [7:0] hp;
  logic       hit_flash;
  logic       phase_done;
  logic       game_over;
  logic [1:0] dbg_fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];

  bullet_wave_scheduler dut (
    .clk(clk), .reset(reset), .state(state), .x(x), .y(y),
    .collision(collision), .bullet_en(bullet_en), .hp(hp),
    .hit_flash(hit_flash), .phase_done(phase_done), .game_over(game_over),
    .dbg_fsm_state(dbg_fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] en, input logic [7:0] h,
                           input logic fl, input logic chk_fl, input logic dn, input logic ov);
    check({tag, " bullet_en"}, 32'(bullet_en), 32'(en));
    check({tag, " hp"}, 32'(hp), 32'(h));
    if (chk_fl) check({tag, " hit_flash"}, 32'(hit_flash), 32'(fl));
    check({tag, " phase_done"}, 32'(phase_done), 32'(dn));
    check({tag, " game_over"}, 32'(game_over), 32'(ov));
  endtask

  // Driver tasks: all inputs change on the falling edge.
  task automatic do_tick(input int hold);
    @(negedge clk);
    x = 10'd639;
    y = 10'd479;
    repeat (hold) @(negedge clk);
    x = 10'd0;
    y = 10'd0;
  endtask

  task automatic do_ticks(input int n, input int hold);
    for (int k = 0; k < n; k++) do_tick(hold);
  endtask

  task automatic do_hit(input logic [3:0] c);
    @(negedge clk);
    collision = c;
    @(negedge clk);
    collision = 4'd0;
  endtask

  task automatic add(input int op, input int arg, input logic [3:0] en, input logic [7:0] h,
                     input logic fl, input logic chk_fl, input logic dn, input logic ov);
    vec_t v;
    v.op = op; v.arg = arg; v.en = en; v.hp = h;
    v.flash = fl; v.chk_flash = chk_fl; v.done = dn; v.over = ov;
    vecs.push_back(v);
  endtask

  initial begin
    // Wave 1: spawn cadence, single hit, ignored hit, timeout.
    add(OP_RESET, 0,  4'b0000, 8'd20, 0, 1, 0, 0);
    add(OP_STATE, 1,  4'b0001, 8'd20, 0, 1, 0, 0);
    add(OP_TICKS, 29, 4'b0001, 8'd20, 0, 1, 0, 0);
    add(OP_TICKS, 1,  4'b0011, 8'd20, 0, 1, 0, 0);
    add(OP_TICKS, 30, 4'b0111, 8'd20, 0, 1, 0, 0);
    add(OP_TICKS, 30, 4'b1111, 8'd20, 0, 1, 0, 0);
    add(OP_HIT,   2,  4'b1101, 8'd16, 1, 1, 0, 0);
    add(OP_TICKS, 59, 4'b1101, 8'd16, 1, 1, 0, 0);
    add(OP_HIT,   1,  4'b1101, 8'd16, 1, 1, 0, 0);
    add(OP_TICKS, 1,  4'b1101, 8'd16, 0, 1, 0, 0);
    add(OP_HIT,   12, 4'b0001, 8'd12, 1, 1, 0, 0);
    add(OP_TICKS, 60, 4'b0001, 8'd12, 0, 1, 0, 0);
    add(OP_TICKS, 88, 4'b0001, 8'd12, 0, 1, 0, 0);
    add(OP_TICKS, 1,  4'b0000, 8'd12, 0, 1, 1, 0);
    add(OP_IDLE,  2,  4'b0000, 8'd12, 0, 1, 0, 0);
    add(OP_STATE, 0,  4'b0000, 8'd12, 0, 1, 0, 0);
    // Wave 2: double hit, hit inside window, early exit at tick 100.
    add(OP_STATE, 1,  4'b0001, 8'd12, 0, 1, 0, 0);
    add(OP_TICKS, 30, 4'b0011, 8'd12, 0, 1, 0, 0);
    add(OP_HIT,   3,  4'b0000, 8'd8,  1, 1, 0, 0);
    add(OP_TICKS, 40, 4'b0100, 8'd8,  1, 1, 0, 0);
    add(OP_HIT,   4,  4'b0100, 8'd8,  1, 1, 0, 0);
    add(OP_TICKS, 20, 4'b1100, 8'd8,  0, 1, 0, 0);
    add(OP_TICKS, 10, 4'b1100, 8'd8,  0, 1, 0, 0);
    add(OP_STATE, 0,  4'b0000, 8'd8,  0, 1, 0, 0);
    add(OP_IDLE,  3,  4'b0000, 8'd8,  0, 1, 0, 0);
    // Wave 3: HP retained, fatal hit, DEAD ignores state until reset.
    add(OP_STATE, 1,  4'b0001, 8'd8,  0, 1, 0, 0);
    add(OP_HIT,   1,  4'b0000, 8'd4,  1, 1, 0, 0);
    add(OP_TICKS, 90, 4'b1110, 8'd4,  0, 1, 0, 0);
    add(OP_HIT,   8,  4'b0000, 8'd0,  0, 0, 0, 1);
    add(OP_STATE, 0,  4'b0000, 8'd0,  0, 0, 0, 1);
    add(OP_STATE, 1,  4'b0000, 8'd0,  0, 0, 0, 1);
    add(OP_TICKS, 5,  4'b0000, 8'd0,  0, 0, 0, 1);
    add(OP_RESET, 0,  4'b0000, 8'd20, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_RESET: begin
          @(negedge clk); reset = 1'b1;
          @(negedge clk); reset = 1'b0;
        end
        OP_STATE: begin
          @(negedge clk); state = 4'(vecs[i].arg);
          @(negedge clk);
        end
        OP_TICKS: do_ticks(vecs[i].arg, 1);
        OP_HIT:   do_hit(4'(vecs[i].arg));
        default:  repeat (vecs[i].arg) @(negedge clk);
      endcase
      check_all($sformatf("v%0d", i), vecs[i].en, vecs[i].hp, vecs[i].flash,
                vecs[i].chk_flash, vecs[i].done, vecs[i].over);
    end

    // Coordinates held at the last pixel for 4 cycles count as one tick.
    @(negedge clk); state = 4'd1;
    @(negedge clk);
    check("hold entry bullet_en", 32'(bullet_en), 32'h1);
    do_ticks(29, 4);
    check("hold 29 ticks bullet_en", 32'(bullet_en), 32'h1);
    do_tick(4);
    check("hold 30 ticks bullet_en", 32'(bullet_en), 32'h3);

    // Tick and hit in the same cycle: the window loads the full length.
    @(negedge clk);
    x = 10'd639; y = 10'd479; collision = 4'b0001;
    @(negedge clk);
    x = 10'd0; y = 10'd0; collision = 4'b0000;
    check("tickhit hp", 32'(hp), 32'd16);
    check("tickhit bullet_en", 32'(bullet_en), 32'h2);
    check("tickhit hit_flash", 32'(hit_flash), 32'h1);
    do_ticks(59, 1);
    check("tickhit +59 hit_flash", 32'(hit_flash), 32'h1);
    do_tick(1);
    check("tickhit +60 hit_flash", 32'(hit_flash), 32'h0);
    check("tick 91 bullet_en", 32'(bullet_en), 32'he);

    // Timeout: phase_done is a single-cycle pulse after tick 299.
    do_ticks(207, 1);
    check("tick 298 phase_done", 32'(phase_done), 32'h0);
    check("tick 298 bullet_en", 32'(bullet_en), 32'he);
    do_tick(1);
    check("tick 299 phase_done", 32'(phase_done), 32'h1);
    check("tick 299 bullet_en", 32'(bullet_en), 32'h0);
    @(negedge clk);
    check("pulse end phase_done", 32'(phase_done), 32'h0);

    // Asynchronous reset mid-wave takes effect without a clock edge.
    @(negedge clk); state = 4'd0;
    @(negedge clk); state = 4'd1;
    @(negedge clk);
    do_ticks(30, 1);
    check("pre-reset bullet_en", 32'(bullet_en), 32'h3);
    check("pre-reset hp", 32'(hp), 32'd16);
    @(negedge clk);
    state = 4'd0;
    #2 reset = 1'b1;
    #1;
    check("async reset bullet_en", 32'(bullet_en), 32'h0);
    check("async reset hp", 32'(hp), 32'd20);
    check("async reset hit_flash", 32'(hit_flash), 32'h0);
    check("async reset game_over", 32'(game_over), 32'h0);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
